// File: rtl/mem_burst_responder.sv
// Word-addressed, byte-writable memory behind the external bus: accepts single/INCR/WRAP
// beats and answers each one with a single ACK after a fixed read latency.
//
// state  | meaning
// IDLE   | waiting for the first beat of a transaction
// ACTIVE | burst in progress, one beat per cycle, counting towards BURST_LENGTH
// DRAIN  | STALL high while outstanding ACKs issue, then TURNAROUND idle cycles
module mem_burst_responder #(
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 1,
    parameter int BURST_LENGTH = 8,
    parameter int TURNAROUND   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ADDR,
    input  logic [1:0]  BURST,
    input  logic        REQ,
    input  logic        WRB,
    input  logic [31:0] WDATA,
    input  logic [3:0]  BSTROBE,
    output logic [31:0] RDATA,
    output logic        ACK,
    output logic        STALL,
    output logic        ERR
);
    localparam int         IW = $clog2(MEM_WORDS);
    localparam logic [3:0] BL = 4'(BURST_LENGTH);
    localparam logic [1:0] TA = 2'(TURNAROUND);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic [3:0]        beat_cnt, beat_cnt_nxt;
    logic [1:0]        ta_cnt, ta_cnt_nxt;
    logic              accept, reserved, do_write, pending;
    logic [IW-1:0]     idx;
    logic [31:0]       in_data;
    logic [31:0]       mem [MEM_WORDS];
    logic [READ_LATENCY-1:0] pv, pe;
    logic [31:0]       pd [READ_LATENCY];
    logic              unused_addr_bits;

    assign idx      = ADDR[IW+1:2];
    assign unused_addr_bits = ^{ADDR[31:IW+2], ADDR[1:0]};
    assign STALL    = (state == S_DRAIN);
    assign accept   = REQ && (state != S_DRAIN);
    assign reserved = (BURST == 2'b11);
    assign do_write = accept && WRB && !reserved;
    assign in_data  = (WRB || reserved) ? '0 : mem[idx];

    // Beats still inside the pipeline but not yet presented on ACK.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < READ_LATENCY - 1; i++) pending = pending | pv[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            ta_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            ta_cnt   <= ta_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        ta_cnt_nxt   = ta_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    ta_cnt_nxt = TA;
                    if (BURST == 2'b00 || reserved || BL <= 4'd1) begin
                        state_nxt    = S_DRAIN;
                        beat_cnt_nxt = '0;
                    end else begin
                        state_nxt    = S_ACTIVE;
                        beat_cnt_nxt = 4'd1;
                    end
                end
            end
            S_ACTIVE: begin
                if (accept) begin
                    ta_cnt_nxt   = TA;
                    beat_cnt_nxt = beat_cnt + 4'd1;
                    if (beat_cnt + 4'd1 == BL) begin
                        state_nxt    = S_DRAIN;
                        beat_cnt_nxt = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (pending) ta_cnt_nxt = TA;
                else if (ta_cnt == 2'd0) state_nxt = S_IDLE;
                else ta_cnt_nxt = ta_cnt - 2'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Array contents survive reset; only enabled bytes are written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++)
                if (BSTROBE[b]) mem[idx][8*b +: 8] <= WDATA[8*b +: 8];
        end
    end

    // Data stages only load when a beat moves in, so RDATA holds between ACKs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pv <= '0;
            pe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pd[i] <= '0;
        end else begin
            pv[0] <= accept;
            pe[0] <= accept && reserved;
            if (accept) pd[0] <= in_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                if (pv[i-1]) pd[i] <= pd[i-1];
            end
        end
    end

    assign ACK   = pv[READ_LATENCY-1];
    assign ERR   = pe[READ_LATENCY-1];
    assign RDATA = pd[READ_LATENCY-1];
endmodule

// File: tb/tb_mem_burst_responder.sv
// Bench for mem_burst_responder: three instances (latency 1/2/4) share one bus and are
// checked against a word-array model and an expected-ACK queue.
module tb_mem_burst_responder;
    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata;
    logic [1:0]  burst;
    logic        req, wrb;
    logic [3:0]  bstrobe;
    logic [31:0] rdata0, rdata1, rdata2;
    logic        ack0, ack1, ack2, stall0, stall1, stall2, err0, err1, err2;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_mem [1024];
    beat_t       exp_q[$], acks0[$], acks1[$], acks2[$];
    logic [31:0] region;

    mem_burst_responder #(.MEM_WORDS(1024), .READ_LATENCY(1), .BURST_LENGTH(8), .TURNAROUND(1)) u_dut (
        .clk(clk), .reset(reset), .ADDR(addr), .BURST(burst), .REQ(req), .WRB(wrb),
        .WDATA(wdata), .BSTROBE(bstrobe), .RDATA(rdata0), .ACK(ack0), .STALL(stall0), .ERR(err0));
    mem_burst_responder #(.MEM_WORDS(1024), .READ_LATENCY(2), .BURST_LENGTH(8), .TURNAROUND(0)) u_lat2 (
        .clk(clk), .reset(reset), .ADDR(addr), .BURST(burst), .REQ(req), .WRB(wrb),
        .WDATA(wdata), .BSTROBE(bstrobe), .RDATA(rdata1), .ACK(ack1), .STALL(stall1), .ERR(err1));
    mem_burst_responder #(.MEM_WORDS(1024), .READ_LATENCY(4), .BURST_LENGTH(8), .TURNAROUND(2)) u_lat4 (
        .clk(clk), .reset(reset), .ADDR(addr), .BURST(burst), .REQ(req), .WRB(wrb),
        .WDATA(wdata), .BSTROBE(bstrobe), .RDATA(rdata2), .ACK(ack2), .STALL(stall2), .ERR(err2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        beat_t t;
        t.cyc = cyc;
        if (ack0) begin t.data = rdata0; t.err = err0; acks0.push_back(t); end
        if (ack1) begin t.data = rdata1; t.err = err1; acks1.push_back(t); end
        if (ack2) begin t.data = rdata2; t.err = err2; acks2.push_back(t); end
    end

    function automatic int lat_of(int inst);
        return (inst == 0) ? 1 : (inst == 1) ? 2 : 4;
    endfunction
    function automatic int ta_of(int inst);
        return (inst == 0) ? 1 : (inst == 1) ? 0 : 2;
    endfunction

    task automatic clear_q();
        exp_q.delete(); acks0.delete(); acks1.delete(); acks2.delete();
    endtask

    task automatic idle(input int n);
        req = 1'b0; burst = 2'b00; wrb = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one beat once every instance is ready; returns just after the accepting edge.
    task automatic do_beat(input logic [31:0] a, input logic [1:0] b, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
        int    n;
        beat_t e;
        logic [9:0] wi;
        n = 0;
        @(negedge clk);
        while ((stall0 || stall1 || stall2) && n < 100) begin
            req = 1'b0;
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL beat_wait: stall still high after %0d cycles, required low", n);
        end
        addr = a; burst = b; wrb = w; wdata = d; bstrobe = s; req = 1'b1;
        wi = a[11:2];
        e.cyc  = cyc;
        e.err  = (b == 2'b11);
        e.data = (w || b == 2'b11) ? 32'h0 : model_mem[wi];
        if (w && b != 2'b11)
            for (int k = 0; k < 4; k++)
                if (s[k]) model_mem[wi][8*k +: 8] = d[8*k +: 8];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 6;
        if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata0); end
        if (ack0 !== 1'b0 || ack1 !== 1'b0 || ack2 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b%b%b want 000", ack0, ack1, ack2); end
        if (stall0 !== 1'b0 || stall1 !== 1'b0 || stall2 !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b%b%b want 000", stall0, stall1, stall2); end
        if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err0); end
        if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata_l2: got %h want 0", rdata1); end
        if (rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rdata_l4: got %h want 0", rdata2); end
    endtask

    task automatic test_incr_read();
        int first;
        clear_q();
        for (int k = 0; k < 8; k++) do_beat(32'h100 + 32'(4*k), 2'b01, 1'b1, 32'hA0 + 32'(k), 4'hF);
        idle(16);
        clear_q();
        for (int k = 0; k < 8; k++) do_beat(32'h100 + 32'(4*k), 2'b01, 1'b0, 32'h0, 4'hF);
        req = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (stall0 !== (j < 2)) begin errors++; $display("FAIL incr_stall cycle %0d: got %b want %b", j, stall0, (j < 2)); end
        end
        idle(16);
        first = exp_q[0].cyc;
        checks++;
        if (acks0.size() != 8) begin errors++; $display("FAIL incr_ack_count: got %0d want 8", acks0.size()); end
        for (int k = 0; k < 8 && k < acks0.size(); k++) begin
            checks++;
            if (acks0[k].cyc != first + 1 + k || acks0[k].data !== 32'hA0 + 32'(k) || acks0[k].err !== 1'b0) begin
                errors++;
                $display("FAIL incr_beat %0d: got cyc=%0d data=%h err=%b, want cyc=%0d data=%h err=0",
                         k, acks0[k].cyc, acks0[k].data, acks0[k].err, first + 1 + k, 32'hA0 + 32'(k));
            end
        end
    endtask

    task automatic test_byte_mask();
        clear_q();
        do_beat(32'h20, 2'b00, 1'b1, 32'hFFFF_FFFF, 4'hF);
        do_beat(32'h20, 2'b00, 1'b1, 32'h1122_3344, 4'b0101);
        do_beat(32'h20, 2'b00, 1'b0, 32'h0, 4'hF);
        idle(16);
        checks += 3;
        if (acks0.size() != 3) begin errors++; $display("FAIL mask_ack_count: got %0d want 3", acks0.size()); end
        else begin
            if (acks0[1].data !== 32'h0) begin errors++; $display("FAIL mask_write_rdata: got %h want 0", acks0[1].data); end
            if (acks0[2].data !== 32'hFF22_FF44) begin errors++; $display("FAIL mask_readback: got %h want ff22ff44", acks0[2].data); end
        end
    endtask

    task automatic test_reserved();
        logic [31:0] v;
        v = $urandom;
        clear_q();
        do_beat(32'h0, 2'b00, 1'b1, v, 4'hF);
        do_beat(32'h0, 2'b11, 1'b1, ~v, 4'hF);
        do_beat(32'h0, 2'b00, 1'b0, 32'h0, 4'hF);
        idle(16);
        checks += 2;
        if (acks0.size() != 3) begin errors++; $display("FAIL rsv_ack_count: got %0d want 3", acks0.size()); end
        else begin
            if (acks0[1].err !== 1'b1 || acks0[1].data !== 32'h0 || acks0[0].err !== 1'b0) begin
                errors++; $display("FAIL rsv_ack: got err=%b data=%h want err=1 data=0", acks0[1].err, acks0[1].data);
            end
            if (acks0[2].data !== v) begin errors++; $display("FAIL rsv_word0: got %h want %h", acks0[2].data, v); end
        end
    endtask

    task automatic test_alias();
        logic [31:0] v;
        v = $urandom;
        clear_q();
        do_beat(32'h1000, 2'b00, 1'b1, v, 4'hF);
        do_beat(32'h0000, 2'b00, 1'b0, 32'h0, 4'hF);
        idle(16);
        checks++;
        if (acks0.size() != 2 || acks0[acks0.size()-1].data !== v) begin
            errors++; $display("FAIL alias_read: got %0d acks last=%h want 2 acks last=%h",
                               acks0.size(), (acks0.size() > 0) ? acks0[acks0.size()-1].data : 32'h0, v);
        end
    endtask

    task automatic test_latency_sweep();
        int sc0, sc1, sc2, s;
        beat_t q[$];
        clear_q();
        region = 32'h400 + 32'($urandom_range(0, 15) * 32);
        for (int k = 0; k < 8; k++) begin
            do_beat(region + 32'(4*k), 2'b01, 1'b1, $urandom, 4'hF);
            if (k == 3) idle(2);
        end
        idle(16);
        s = $urandom_range(0, 7);
        for (int k = 0; k < 8; k++) do_beat(region + 32'(4*((s + k) % 8)), 2'b10, 1'b0, 32'h0, 4'hF);
        req = 1'b0;
        sc0 = 0; sc1 = 0; sc2 = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            sc0 += int'(stall0); sc1 += int'(stall1); sc2 += int'(stall2);
        end
        idle(16);
        for (int inst = 0; inst < 3; inst++) begin
            case (inst)
                0: q = acks0;
                1: q = acks1;
                default: q = acks2;
            endcase
            checks += 2;
            if (q.size() != exp_q.size()) begin errors++; $display("FAIL lat%0d_ack_count: got %0d want %0d", lat_of(inst), q.size(), exp_q.size()); end
            if (((inst == 0) ? sc0 : (inst == 1) ? sc1 : sc2) != lat_of(inst) + ta_of(inst)) begin
                errors++; $display("FAIL lat%0d_stall_len: got %0d want %0d", lat_of(inst),
                                   (inst == 0) ? sc0 : (inst == 1) ? sc1 : sc2, lat_of(inst) + ta_of(inst));
            end
            for (int k = 0; k < exp_q.size() && k < q.size(); k++) begin
                checks++;
                if (q[k].cyc != exp_q[k].cyc + lat_of(inst) || q[k].data !== exp_q[k].data || q[k].err !== exp_q[k].err) begin
                    errors++;
                    $display("FAIL lat%0d_beat %0d: got cyc=%0d data=%h err=%b, want cyc=%0d data=%h err=%b", lat_of(inst), k,
                             q[k].cyc, q[k].data, q[k].err, exp_q[k].cyc + lat_of(inst), exp_q[k].data, exp_q[k].err);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        clear_q();
        for (int k = 0; k < 8; k += 2) begin
            a = region + 32'(4*$urandom_range(0, 7));
            do_beat(a, 2'b01, 1'b1, $urandom, 4'($urandom_range(0, 15)));
            do_beat(a, 2'b01, 1'b0, 32'h0, 4'hF);
        end
        do_beat(a, 2'b00, 1'b0, 32'h0, 4'hF);
        idle(16);
        checks += 3;
        if (exp_q[8].cyc - exp_q[0].cyc != 14) begin
            errors++; $display("FAIL b2b_period: got %0d want 14", exp_q[8].cyc - exp_q[0].cyc);
        end
        if (acks1.size() != 9 || acks2.size() != 9) begin
            errors++; $display("FAIL b2b_ack_count: got %0d/%0d want 9/9", acks1.size(), acks2.size());
        end
        if (acks0.size() != exp_q.size()) begin errors++; $display("FAIL b2b_ack_count_main: got %0d want %0d", acks0.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < acks0.size(); k++) begin
            checks++;
            if (acks0[k].cyc != exp_q[k].cyc + 1 || acks0[k].data !== exp_q[k].data || acks0[k].err !== exp_q[k].err) begin
                errors++;
                $display("FAIL b2b_beat %0d: got cyc=%0d data=%h, want cyc=%0d data=%h",
                         k, acks0[k].cyc, acks0[k].data, exp_q[k].cyc + 1, exp_q[k].data);
            end
        end
    endtask

    task automatic test_reset_midburst();
        clear_q();
        for (int k = 0; k < 3; k++) do_beat(region + 32'(4*k), 2'b01, 1'b0, 32'h0, 4'hF);
        req = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (ack0 !== 1'b0 || ack1 !== 1'b0 || ack2 !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %b%b%b want 000", ack0, ack1, ack2); end
        if (stall0 !== 1'b0 || stall1 !== 1'b0 || stall2 !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b%b%b want 000", stall0, stall1, stall2); end
        if (rdata0 !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h want 0", rdata0); end
        clear_q();
        @(posedge clk);
        #1 reset = 1'b0;
        idle(16);
        checks++;
        if (acks0.size() + acks1.size() + acks2.size() != 0) begin
            errors++; $display("FAIL rstmid_stale: got %0d/%0d/%0d acks want 0", acks0.size(), acks1.size(), acks2.size());
        end
        clear_q();
        for (int k = 0; k < 8; k++) do_beat(region + 32'(4*k), 2'b01, 1'b0, 32'h0, 4'hF);
        idle(16);
        checks++;
        if (acks0.size() != 8 || acks2.size() != 8) begin errors++; $display("FAIL rstmid_next_count: got %0d/%0d want 8/8", acks0.size(), acks2.size()); end
        for (int k = 0; k < 8 && k < acks0.size(); k++) begin
            checks++;
            if (acks0[k].cyc != exp_q[k].cyc + 1 || acks0[k].data !== exp_q[k].data) begin
                errors++;
                $display("FAIL rstmid_next_beat %0d: got cyc=%0d data=%h, want cyc=%0d data=%h",
                         k, acks0[k].cyc, acks0[k].data, exp_q[k].cyc + 1, exp_q[k].data);
            end
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; addr = '0; burst = 2'b00; wrb = 1'b0; wdata = '0; bstrobe = '0;
        region = 32'h400;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        idle(2);
        test_incr_read();
        test_byte_mask();
        test_reserved();
        test_alias();
        test_latency_sweep();
        test_back_to_back();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_burst_responder.md
# mem_burst_responder

Memory-side responder for the core's external memory bus: it accepts single and burst transactions from the IMEM/DMEM interface router (ADDR/BURST/REQ/WRB/WDATA/BSTROBE) and answers with RDATA/ACK/STALL. It backs the bus with a word-addressed, byte-writable memory array. The array serves as the core's simulation and FPGA main memory, and as the bus-compliance target for the router.

## Interface
- MEM_WORDS, 1024: array depth in 32-bit words; power of two; index bits IW = log2(MEM_WORDS).
- READ_LATENCY, 1: cycles from beat acceptance to its ACK; legal range 1..4.
- BURST_LENGTH, 8: beats per INCR/WRAP burst.
- TURNAROUND, 1: idle STALL cycles after a transaction's last ACK; legal range 0..3.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- ADDR  in  32  byte address of the current beat; bits [1:0] are ignored.
- BURST  in  2  00 single, 01 INCR, 10 WRAP, 11 reserved.
- REQ  in  1  beat request, held high by the initiator through the transaction.
- WRB  in  1  1 = write beat, 0 = read beat.
- WDATA  in  32  write data.
- BSTROBE  in  4  byte enables; bit n covers WDATA[8n+7:8n].
- RDATA  out  32  read data, valid when ACK=1.
- ACK  out  1  one-cycle pulse per accepted beat.
- STALL  out  1  when high, no beat is accepted this cycle.
- ERR  out  1  pulses together with the ACK of a reserved-BURST beat.

## Operation
- **Acceptance:** a beat is accepted in any cycle with REQ=1 and STALL=0. The word index is ADDR[IW+1:2]; higher address bits are ignored, so addresses alias modulo the array size.
- **Address handling:** the responder uses ADDR exactly as presented on each beat. Address increment and wrap are the initiator's job.
- **States:**
  - IDLE: the first accepted beat latches the BURST type and moves to ACTIVE. For a single or reserved beat it moves directly to DRAIN.
  - ACTIVE: beats are counted with a 4-bit counter. The accept that makes the count reach BURST_LENGTH moves to DRAIN. STALL=0 throughout ACTIVE.
  - DRAIN: STALL=1 until the last outstanding ACK has issued, then stays high for TURNAROUND more cycles, then returns to IDLE. With TURNAROUND=0, the state returns to IDLE in the cycle after the last ACK.
- **Writes:** the array is updated at the accepting clock edge, for the enabled bytes only. Disabled bytes keep their old value. BSTROBE=0000 writes nothing but still gets an ACK.
- **Reads:** the array is sampled at the accepting edge. A read following a write to the same word in the next cycle returns the new data.
- **ACK pipeline:** a READ_LATENCY-deep shift register of {valid, data, err}. Every accepted beat, read or write, gets exactly one ACK.
- **RDATA values:** on a write ACK, RDATA = 0. Outside ACK cycles, RDATA holds its last value.
- **Reserved BURST=11:** the beat is treated as a single. No write occurs, RDATA = 0 and ERR = 1 with its ACK.
- **Burst type:** BURST and WRB are sampled per beat for data direction. The burst type is sampled only at the first beat.
- **REQ dropped mid-burst:** the state stays ACTIVE and waits. There is no timeout.

## Timing
- **Reset values:** RDATA = 0, ACK = 0, STALL = 0, ERR = 0, state IDLE, beat counter 0. The ACK pipeline is flushed; pending ACKs are discarded, including when reset lands mid-burst. Array contents are not reset.
- **Read latency:** a beat accepted at edge t gets its ACK (and RDATA) in the cycle after edge t+READ_LATENCY-1. With the default of 1, ACK appears in the cycle after acceptance.
- **Back-to-back throughput:** 1 beat per cycle in ACTIVE. An ACK for beat k and acceptance of beat k+READ_LATENCY can occur in the same cycle.
- **STALL timing:** STALL rises in the cycle after the final accept of a transaction. STALL is registered; it has no combinational path from REQ.
- **Minimum transaction period:**
  - Burst: BURST_LENGTH + READ_LATENCY + TURNAROUND cycles from the first accept to the next possible accept.
  - Single: 1 + READ_LATENCY + TURNAROUND cycles.

## Test plan
- **INCR read burst:** preload words 0x40..0x47 with 0xA0..0xA7. Issue an INCR read at ADDR 0x100 with READ_LATENCY=1. Expect 8 consecutive ACKs with RDATA 0xA0..0xA7, then STALL=1 for 1+TURNAROUND cycles.
- **Byte-masked write:** write 0x11223344 to ADDR 0x20 with BSTROBE=0101 onto 0xFFFFFFFF, then read it back. Expect 0xFF22FF44; the write ACK carries RDATA=0.
- **Latency sweep:** run READ_LATENCY = 1, 2, 4 with 8 beats each. Expect the first ACK exactly READ_LATENCY cycles after the first accept, no missing or duplicate ACKs, and the ACK count equal to the accept count.
- **Reserved burst:** a single beat with BURST=11 and WRB=1 to ADDR 0x0. Expect ACK with ERR=1 and RDATA=0, and word 0 unchanged.
- **Reset mid-burst:** assert reset after 3 of 8 accepted beats. Expect ACK=0 and STALL=0 the next cycle and no stale ACKs after release. A following burst completes normally.
- **Aliasing and router integration:** with MEM_WORDS=1024, a write to 0x1000 must read back at 0x0000. Run a full interface_router INCR read/write cycle against this block and compare the 256-bit line.
